// File: rtl/alu_issue_if.sv
// Instruction handshake between the fetch side and the alu_issue decode/issue stage.
interface alu_issue_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue.sv
// Decode/issue stage: decodes 16-bit instructions, reads the register file, drives the ALU,
// stalls on RAW hazards against in-flight destinations and writes ALU results back.
module alu_issue #(
    parameter int N       = 16,
    parameter int ALU_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_if.slave    up,
    output logic [N-1:0]  alu_A,
    output logic [N-1:0]  alu_B,
    output logic [3:0]    alu_opcode,
    input  logic [N-1:0]  alu_result,
    input  logic          Z,
    input  logic          C,
    input  logic          Nf,
    input  logic          V,
    output logic [3:0]    flags_q,
    output logic          illegal,
    output logic          busy,
    output logic [15:0]   retired,
    input  logic [2:0]    dbg_addr,
    output logic [N-1:0]  dbg_data
);

    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_ASR = 4'b1010;

    function automatic logic op_legal(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == OP_ASR);
    endfunction

    function automatic logic [N-1:0] imm_ext(input logic [4:0] imm);
        return {{(N-5){1'b0}}, imm};
    endfunction

    logic [N-1:0] regs [8];

    // Tracker: slot 0 is loaded at the accept edge, the last slot is the writeback slot.
    logic [ALU_LAT-1:0] trk_vld;
    logic [2:0]         trk_rd [ALU_LAT];

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       imm_sel;
    logic       legal;
    logic       hazard_rs1;
    logic       hazard_rs2;
    logic       hazard;
    logic       accept;
    logic       issue;
    logic       wb_vld;
    logic [2:0] wb_rd;

    assign op      = up.instr[15:12];
    assign rd      = up.instr[11:9];
    assign rs1     = up.instr[8:6];
    assign imm_sel = up.instr[5];
    assign rs2     = up.instr[2:0];
    assign legal   = op_legal(op);

    // No bypass: the writeback slot still blocks a reader until the value is in regs.
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        for (int i = 0; i < ALU_LAT; i++) begin
            if (trk_vld[i] && (trk_rd[i] != 3'd0)) begin
                if ((rs1 != 3'd0) && (rs1 == trk_rd[i]))
                    hazard_rs1 = 1'b1;
                if ((rs2 != 3'd0) && (rs2 == trk_rd[i]))
                    hazard_rs2 = 1'b1;
            end
        end
        hazard = legal && (hazard_rs1 || (!imm_sel && (op != OP_NOT) && hazard_rs2));
    end

    assign up.instr_ready = rst && !hazard;
    assign accept         = up.instr_valid && up.instr_ready;
    assign issue          = accept && legal;

    assign wb_vld   = trk_vld[ALU_LAT-1];
    assign wb_rd    = trk_rd[ALU_LAT-1];
    assign busy     = |trk_vld;
    assign dbg_data = regs[dbg_addr];

    // Issue stage: operands sampled from pre-edge register state; bubbles drive zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= 4'b0000;
        end else if (issue) begin
            alu_A      <= regs[rs1];
            alu_B      <= imm_sel ? imm_ext(up.instr[4:0]) : regs[rs2];
            alu_opcode <= op;
        end else begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_vld <= '0;
            for (int i = 0; i < ALU_LAT; i++)
                trk_rd[i] <= 3'd0;
        end else begin
            for (int i = ALU_LAT - 1; i > 0; i--) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_rd[i]  <= trk_rd[i-1];
            end
            trk_vld[0] <= issue;
            trk_rd[0]  <= issue ? rd : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal <= 1'b0;
        else if (accept && !legal)
            illegal <= 1'b1;
    end

    // Writeback stage: flags and the retire count update even when rd is r0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
            flags_q <= 4'b0000;
            retired <= 16'd0;
        end else if (wb_vld) begin
            if (wb_rd != 3'd0)
                regs[wb_rd] <= alu_result;
            flags_q <= {Z, C, Nf, V};
            retired <= retired + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: latency-2 ALU stand-in, directed vector table, hazard/reset/wrap
// sequences and randomized traffic checked against a queue-based reference model.
module tb_alu_issue;

    localparam int N       = 16;
    localparam int ALU_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  alu_A, alu_B, alu_result;
    logic [3:0]    alu_opcode, flags_q;
    logic          Z, C, Nf, V, illegal, busy;
    logic [15:0]   retired;
    logic [2:0]    dbg_addr = 3'd0;
    logic [N-1:0]  dbg_data;

    alu_issue_if up ();

    alu_issue #(.N(N), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .up(up),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .Z(Z), .C(C), .Nf(Nf), .V(V),
        .flags_q(flags_q), .illegal(illegal), .busy(busy), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Returns {Z,C,Nf,V,result}
    function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = 16'd0; w = 17'd0;
        case (op)
            4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  r = a << b[3:0];
            4'd7:  r = a >> b[3:0];
            4'd10: r = 16'($signed(a) >>> b[3:0]);
            default: r = 16'd0;
        endcase
        return {(r == 16'd0), c, r[15], v, r};
    endfunction

    // ALU stand-in: one register stage gives ALU_LAT=2 from operand edge to sample edge.
    logic [19:0] alu_q = 20'd0;
    always @(posedge clk) alu_q <= alu_f(alu_opcode, alu_A, alu_B);
    assign alu_result = alu_q[15:0];
    assign {Z, C, Nf, V} = alu_q[19:16];

    typedef struct { int due; logic [2:0] rd; logic [19:0] out; } pend_t;
    pend_t       pend[$];
    logic [15:0] ref_regs [8];
    logic [3:0]  ref_flags;
    logic [15:0] ref_retired;
    logic        ref_illegal;
    int          edge_cnt = 0;
    int          nchk = 0;
    int          nerr = 0;
    logic        last_dut_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int im, input int low);
        return {4'(op), 3'(rd), 3'(rs1), 1'(im), 5'(low)};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'd7) || (op == 4'd10);
    endfunction

    // Ready per the hazard rules: a source register written by any not-yet-retired instruction blocks.
    function automatic logic model_ready(input logic [15:0] ins);
        logic [3:0] op;
        logic [2:0] rs1, rs2;
        logic       blocked;
        op = ins[15:12]; rs1 = ins[8:6]; rs2 = ins[2:0];
        blocked = 1'b0;
        if (!rst) return 1'b0;
        if (!is_legal(op)) return 1'b1;
        foreach (pend[i]) begin
            if (pend[i].rd != 3'd0) begin
                if (rs1 == pend[i].rd) blocked = 1'b1;
                if (!ins[5] && op != 4'd5 && rs2 == pend[i].rd) blocked = 1'b1;
            end
        end
        return !blocked;
    endfunction

    task automatic model_clear();
        pend.delete();
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        ref_flags = 4'd0; ref_retired = 16'd0; ref_illegal = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [15:0] ins);
        logic [3:0]  op;
        logic [2:0]  da;
        logic        exp_rdy;
        logic [15:0] ea, eb;
        logic [3:0]  eo;
        pend_t       p;
        op = ins[15:12];
        da = 3'($urandom_range(0, 7));
        up.instr_valid = v; up.instr = ins; dbg_addr = da;
        #1;
        exp_rdy = model_ready(ins);
        last_dut_rdy = up.instr_ready;
        check("instr_ready", 32'(up.instr_ready), 32'(exp_rdy));
        check("dbg_data", 32'(dbg_data), 32'(ref_regs[da]));
        ea = 16'd0; eb = 16'd0; eo = 4'd0;
        if (v && exp_rdy) begin
            if (is_legal(op)) begin
                ea = ref_regs[ins[8:6]];
                eb = ins[5] ? {11'd0, ins[4:0]} : ref_regs[ins[2:0]];
                eo = op;
                pend.push_back('{edge_cnt + 1 + ALU_LAT, ins[11:9], alu_f(op, ea, eb)});
            end else begin
                ref_illegal = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        edge_cnt++;
        while (pend.size() > 0 && pend[0].due == edge_cnt) begin
            p = pend.pop_front();
            if (p.rd != 3'd0) ref_regs[p.rd] = p.out[15:0];
            ref_flags = p.out[19:16];
            ref_retired = ref_retired + 16'd1;
        end
        check("alu_A", 32'(alu_A), 32'(ea));
        check("alu_B", 32'(alu_B), 32'(eb));
        check("alu_opcode", 32'(alu_opcode), 32'(eo));
        check("flags_q", 32'(flags_q), 32'(ref_flags));
        check("retired", 32'(retired), 32'(ref_retired));
        check("busy", 32'(busy), 32'(pend.size() != 0));
        check("illegal", 32'(illegal), 32'(ref_illegal));
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic do_reset();
        up.instr_valid = 1'b0; up.instr = 16'd0;
        rst = 1'b0;
        #1;
        model_clear();
        check("rst_ready", 32'(up.instr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_alu", {alu_A, alu_B}, 32'd0);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        check("rst_flags", 32'(flags_q), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct { logic [15:0] ins; logic [2:0] sel; logic [15:0] val; logic z; } vec_t;
    vec_t vt [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int          stalls;
        logic [3:0]  rop;
        up.instr_valid = 1'b0; up.instr = 16'd0;
        model_clear();
        #2;
        do_reset();

        // Immediate loads back to back
        cycle(1, enc(0, 1, 0, 1, 5));
        check("imm1_ready", 32'(last_dut_rdy), 32'd1);
        cycle(1, enc(0, 2, 0, 1, 9));
        check("imm2_ready", 32'(last_dut_rdy), 32'd1);
        repeat (3) cycle(0, 16'd0);
        read_reg(3'd1, d); check("imm_r1", 32'(d), 32'd5);
        read_reg(3'd2, d); check("imm_r2", 32'(d), 32'd9);
        check("imm_retired", 32'(retired), 32'd2);

        // RAW stall: dependent instruction waits exactly ALU_LAT cycles
        cycle(1, enc(0, 1, 0, 1, 5));
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1, enc(0, 2, 1, 1, 3));
            if (last_dut_rdy) break;
            stalls++;
        end
        check("raw_stall_cycles", 32'(stalls), 32'd2);
        check("raw_busy_inflight", 32'(busy), 32'd1);
        repeat (2) cycle(0, 16'd0);
        check("raw_busy_done", 32'(busy), 32'd0);
        read_reg(3'd2, d); check("raw_r2", 32'(d), 32'd8);

        // Vector table: one instruction at a time, result checked after writeback
        vt[0] = '{enc(0, 1, 0, 1, 5),  3'd1, 16'd5,      1'b0};
        vt[1] = '{enc(6, 4, 1, 1, 3),  3'd4, 16'd40,     1'b0};
        vt[2] = '{enc(1, 6, 1, 0, 1),  3'd6, 16'd0,      1'b1};
        vt[3] = '{enc(0, 0, 1, 0, 1),  3'd0, 16'd0,      1'b0};
        vt[4] = '{enc(4, 2, 1, 1, 3),  3'd2, 16'd6,      1'b0};
        vt[5] = '{enc(5, 3, 1, 0, 0),  3'd3, 16'hFFFA,   1'b0};
        vt[6] = '{enc(10, 5, 3, 1, 2), 3'd5, 16'hFFFE,   1'b0};
        vt[7] = '{enc(7, 7, 3, 1, 4),  3'd7, 16'h0FFF,   1'b0};
        vt[8] = '{enc(2, 2, 3, 0, 1),  3'd2, 16'd0,      1'b1};
        vt[9] = '{enc(3, 2, 4, 0, 1),  3'd2, 16'h002D,   1'b0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) begin
                cycle(1, vt[i].ins);
                if (last_dut_rdy) break;
            end
            repeat (3) cycle(0, 16'd0);
            read_reg(vt[i].sel, d);
            check($sformatf("vec%0d_reg", i), 32'(d), 32'(vt[i].val));
            check($sformatf("vec%0d_z", i), 32'(flags_q[3]), 32'(vt[i].z));
            check($sformatf("vec%0d_retired", i), 32'(retired), 32'(i + 1));
        end

        // Illegal opcode is a bubble that sets the sticky flag
        cycle(1, 16'hF200);
        check("ill_ready", 32'(last_dut_rdy), 32'd1);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_opcode", 32'(alu_opcode), 32'd0);
        repeat (3) cycle(0, 16'd0);
        check("ill_retired", 32'(retired), 32'd10);
        read_reg(3'd1, d); check("ill_r1", 32'(d), 32'd5);
        cycle(1, enc(0, 3, 0, 1, 1));
        repeat (3) cycle(0, 16'd0);
        check("ill_sticky", 32'(illegal), 32'd1);

        // Reset mid-flight discards the in-flight instruction
        cycle(1, enc(0, 5, 0, 1, 7));
        do_reset();
        repeat (3) cycle(0, 16'd0);
        check("rstf_ready_after", 32'(last_dut_rdy), 32'd1);
        read_reg(3'd5, d); check("rstf_r5", 32'(d), 32'd0);
        check("rstf_retired", 32'(retired), 32'd0);
        check("rstf_busy", 32'(busy), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0)
                rop = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'($urandom_range(11, 15));
            else begin
                rop = 4'($urandom_range(0, 8));
                if (rop == 4'd8) rop = 4'd10;
            end
            cycle($urandom_range(0, 4) != 0,
                  {rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom)});
        end
        repeat (3) cycle(0, 16'd0);

        // Retire counter wrap with r0 destinations (never hazards)
        do_reset();
        for (int i = 0; i < 65536; i++) cycle(1, enc(0, 0, 0, 1, 1));
        check("wrap_pre", 32'(retired), 32'hFFFE);
        repeat (2) cycle(0, 16'd0);
        check("wrap_zero", 32'(retired), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
